mem_arbiter: RTL and testbench

Parametrised successor to the single-byte memory controller: serialises multi-byte load/store requests from the load-store buffer and burst line fills from the instruction fetch path onto the byte-wide, one-cycle-latency RAM port. It assembles little-endian read data, splits write data into bytes, stalls writes to the I/O region while the I/O buffer is full, and supports aborting an in-flight fetch burst on pipeline flush. Sits between the core's memory clients and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

---
 rtl/mem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Serialises multi-byte load/store requests from the load-store buffer and
//   burst line fills from the fetch path onto a byte-wide RAM port with a
//   one-cycle read latency. Read bytes are assembled little-endian, write
//   words are split into bytes, and writes to the I/O region stall while the
//   I/O buffer is full. An in-flight fetch burst can be aborted by a flush.
//
// Parameters
//   LINE_BYTES  bytes per fetch burst (power of two, 4..64)
//   IO_ADDR_HI  value of addr[17:16] that marks the I/O region
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   mem_din/mem_dout        RAM read byte / RAM write byte
//   mem_a, mem_wr           RAM byte address, write strobe
//   io_buffer_full          I/O sink cannot accept a write
//   lsb_req/wr/size/addr/wdata, lsb_rdata, lsb_done     load-store client
//   fetch_req/addr/flush, fetch_data, fetch_done         line-fill client
//
// Build option
//   MEM_ARB_RR_EN  defined: round-robin arbitration between the two clients;
//                  undefined: the load-store client always wins.
module mem_arbiter #(
  parameter int         LINE_BYTES = 16,
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [1:0]              lsb_size,
  input  logic [31:0]             lsb_addr,
  input  logic [31:0]             lsb_wdata,
  output logic [31:0]             lsb_rdata,
  output logic                    lsb_done,
  input  logic                    fetch_req,
  input  logic [31:0]             fetch_addr,
  input  logic                    fetch_flush,
  output logic [LINE_BYTES*8-1:0] fetch_data,
  output logic                    fetch_done
);

  localparam int CW = $clog2(LINE_BYTES) + 1;
  localparam logic [31:0] OFF_MASK = 32'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           len_q, len_d;
  logic                    is_fetch_q, is_fetch_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             lsb_rdata_q, lsb_rdata_d;
  logic [LINE_BYTES*8-1:0] fetch_data_q, fetch_data_d;
`ifdef MEM_ARB_RR_EN
  logic                    prio_fetch_q, prio_fetch_d;
`endif

  logic          fetch_ok;
  logic          pick_fetch;
  logic          last_byte;
  logic          stall;
  logic [CW-1:0] cap_idx;
  logic [CW+2:0] cap_bit;

  assign lsb_rdata  = lsb_rdata_q;
  assign fetch_data = fetch_data_q;

  // Next-state, datapath and RAM-port outputs. The RAM port is driven only
  // while a byte is actually being issued; everywhere else it reads as zero.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    is_fetch_d   = is_fetch_q;
    wdata_d      = wdata_q;
    lsb_rdata_d  = lsb_rdata_q;
    fetch_data_d = fetch_data_q;
`ifdef MEM_ARB_RR_EN
    prio_fetch_d = prio_fetch_q;
`endif
    mem_a      = 32'd0;
    mem_wr     = 1'b0;
    mem_dout   = 8'd0;
    lsb_done   = 1'b0;
    fetch_done = 1'b0;

    // A fetch that arrives together with a flush is never accepted.
    fetch_ok = fetch_req && !fetch_flush;
`ifdef MEM_ARB_RR_EN
    pick_fetch = fetch_ok && (!lsb_req || prio_fetch_q);
`else
    pick_fetch = fetch_ok && !lsb_req;
`endif

    last_byte = (cnt_q == len_q - CW'(1));
    stall     = (base_q[17:16] == IO_ADDR_HI) && io_buffer_full;

    // RAM data lags its address by one cycle, so the byte arriving now
    // belongs to the address issued when the counter was one lower.
    cap_idx = cnt_q - CW'(1);
    cap_bit = {cap_idx, 3'b000};
    if ((state_q == READ && cnt_q != '0) || state_q == DRAIN) begin
      if (is_fetch_q) begin
        fetch_data_d[cap_bit +: 8] = mem_din;
      end else begin
        lsb_rdata_d[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
      end
    end

    case (state_q)
      IDLE: begin
        if (lsb_req && !pick_fetch) begin
          base_d     = lsb_addr;
          cnt_d      = '0;
          is_fetch_d = 1'b0;
          wdata_d    = lsb_wdata;
          case (lsb_size)
            2'd0:    len_d = CW'(1);
            2'd1:    len_d = CW'(2);
            default: len_d = CW'(4);
          endcase
          if (lsb_wr) begin
            state_d = WRITE;
          end else begin
            // Cleared up front so the unused upper bytes read as zero.
            lsb_rdata_d = 32'd0;
            state_d     = READ;
          end
        end else if (pick_fetch) begin
          base_d     = fetch_addr & ~OFF_MASK;
          cnt_d      = '0;
          len_d      = CW'(LINE_BYTES);
          is_fetch_d = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        mem_a = base_q + 32'(cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (last_byte) begin
          state_d = DRAIN;
        end
        if (is_fetch_q && fetch_flush) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        state_d = DONE;
        if (is_fetch_q && fetch_flush) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_a    = base_q + 32'(cnt_q);
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (!stall) begin
          mem_wr = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (last_byte) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_fetch_q) begin
          if (!fetch_flush) begin
            fetch_done = 1'b1;
`ifdef MEM_ARB_RR_EN
            prio_fetch_d = 1'b0;
`endif
          end
        end else begin
          lsb_done = 1'b1;
`ifdef MEM_ARB_RR_EN
          prio_fetch_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also drops any burst in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      base_q       <= 32'd0;
      cnt_q        <= '0;
      len_q        <= '0;
      is_fetch_q   <= 1'b0;
      wdata_q      <= 32'd0;
      lsb_rdata_q  <= 32'd0;
      fetch_data_q <= '0;
`ifdef MEM_ARB_RR_EN
      prio_fetch_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      is_fetch_q   <= is_fetch_d;
      wdata_q      <= wdata_d;
      lsb_rdata_q  <= lsb_rdata_d;
      fetch_data_q <= fetch_data_d;
`ifdef MEM_ARB_RR_EN
      prio_fetch_q <= prio_fetch_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, scoreboarded bench for mem_arbiter. A behavioural byte RAM with
// one-cycle read latency sits on the memory port; expected read results are
// queued when a request is driven and popped when the matching done pulse
// appears.
module tb_mem_arbiter;

  localparam int LB = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [7:0]      mem_din;
  logic [7:0]      mem_dout;
  logic [31:0]     mem_a;
  logic            mem_wr;
  logic            io_buffer_full;
  logic            lsb_req;
  logic            lsb_wr;
  logic [1:0]      lsb_size;
  logic [31:0]     lsb_addr;
  logic [31:0]     lsb_wdata;
  logic [31:0]     lsb_rdata;
  logic            lsb_done;
  logic            fetch_req;
  logic [31:0]     fetch_addr;
  logic            fetch_flush;
  logic [LB*8-1:0] fetch_data;
  logic            fetch_done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ram[logic [31:0]];

  mem_arbiter #(.LINE_BYTES(LB), .IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_rdata(lsb_rdata), .lsb_done(lsb_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_data(fetch_data), .fetch_done(fetch_done)
  );

  always #5 clk_in = ~clk_in;

  // Unwritten locations return a fixed address-derived pattern.
  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // RAM: read data appears the cycle after its address; writes land on the edge.
  always @(posedge clk_in) begin
    mem_din <= rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic lreq, input logic lwr,
                               input logic [1:0] lsize, input logic [31:0] laddr,
                               input logic [31:0] lwdata, input logic freq,
                               input logic [31:0] faddr);
    lsb_req    = lreq;
    lsb_wr     = lwr;
    lsb_size   = lsize;
    lsb_addr   = laddr;
    lsb_wdata  = lwdata;
    fetch_req  = freq;
    fetch_addr = faddr;
  endtask

  // Waits (bounded) for the chosen done pulse, sampling on falling edges.
  task automatic waitDone(input bit want_fetch, input string tag);
    int n = 0;
    while (n < 40 && !(want_fetch ? fetch_done : lsb_done)) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput({tag, "_done"}, 32'(want_fetch ? fetch_done : lsb_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w;
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;
    rst_in = 1'b1;
    io_buffer_full = 1'b0;
    fetch_flush = 1'b0;
    applyStimulus(0, 0, 2'd0, 32'd0, 32'd0, 0, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_mem_dout", 32'(mem_dout), 32'd0);
    checkOutput("rst_lsb_done", 32'(lsb_done), 32'd0);
    checkOutput("rst_fetch_done", 32'(fetch_done), 32'd0);
    checkOutput("rst_lsb_rdata", lsb_rdata, 32'd0);
    checkOutput("rst_fetch_data", fetch_data[31:0], 32'd0);

    // Load word from 0x100.
    applyStimulus(1, 0, 2'd2, 32'h100, 32'd0, 0, 32'd0);
    exp_q.push_back(32'h44332211);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (c <= 4) checkOutput($sformatf("ldw_a%0d", c), mem_a, 32'h100 + 32'(c - 1));
      else if (c == 5) checkOutput("ldw_drain_a", mem_a, 32'd0);
      checkOutput($sformatf("ldw_wr%0d", c), 32'(mem_wr), 32'd0);
      checkOutput($sformatf("ldw_done%0d", c), 32'(lsb_done), 32'(c == 6));
    end
    checkOutput("ldw_rdata", lsb_rdata, exp_q.pop_front());
    lsb_req = 1'b0;
    @(negedge clk_in);

    // Store half 0xBEEF to 0x203.
    applyStimulus(1, 1, 2'd1, 32'h203, 32'h0000BEEF, 0, 32'd0);
    @(negedge clk_in);
    checkOutput("sth_a1", mem_a, 32'h203);
    checkOutput("sth_d1", 32'(mem_dout), 32'hEF);
    checkOutput("sth_wr1", 32'(mem_wr), 32'd1);
    @(negedge clk_in);
    checkOutput("sth_a2", mem_a, 32'h204);
    checkOutput("sth_d2", 32'(mem_dout), 32'hBE);
    checkOutput("sth_done2", 32'(lsb_done), 32'd0);
    @(negedge clk_in);
    checkOutput("sth_done3", 32'(lsb_done), 32'd1);
    checkOutput("sth_wr3", 32'(mem_wr), 32'd0);
    lsb_req = 1'b0;
    @(negedge clk_in);

    // Read the half back across the word boundary.
    applyStimulus(1, 0, 2'd1, 32'h203, 32'd0, 0, 32'd0);
    exp_q.push_back(32'h0000BEEF);
    waitDone(0, "ldh");
    checkOutput("ldh_rdata", lsb_rdata, exp_q.pop_front());
    lsb_req = 1'b0;
    @(negedge clk_in);

    // Byte store into the I/O region while the I/O buffer is full.
    applyStimulus(1, 1, 2'd0, 32'h30000, 32'h0000005A, 0, 32'd0);
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      checkOutput($sformatf("io_stall_wr%0d", c), 32'(mem_wr), 32'd0);
      checkOutput($sformatf("io_stall_done%0d", c), 32'(lsb_done), 32'd0);
    end
    @(posedge clk_in);
    #1 io_buffer_full = 1'b0;
    @(negedge clk_in);
    checkOutput("io_wr", 32'(mem_wr), 32'd1);
    checkOutput("io_a", mem_a, 32'h30000);
    checkOutput("io_d", 32'(mem_dout), 32'h5A);
    @(negedge clk_in);
    checkOutput("io_done", 32'(lsb_done), 32'd1);
    checkOutput("io_wr_after", 32'(mem_wr), 32'd0);
    lsb_req = 1'b0;
    @(negedge clk_in);

    // Line fill from an unaligned address.
    applyStimulus(0, 0, 2'd0, 32'd0, 32'd0, 1, 32'h1008);
    for (int i = 0; i < LB / 4; i++) begin
      for (int b = 0; b < 4; b++) w[b*8 +: 8] = rd(32'h1000 + 32'(i * 4 + b));
      exp_q.push_back(w);
    end
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_in);
      if (c <= 16) checkOutput($sformatf("fet_a%0d", c), mem_a, 32'h1000 + 32'(c - 1));
      else if (c == 17) checkOutput("fet_drain_a", mem_a, 32'd0);
      checkOutput($sformatf("fet_done%0d", c), 32'(fetch_done), 32'(c == 18));
    end
    fetch_req = 1'b0;
    for (int i = 0; i < LB / 4; i++)
      checkOutput($sformatf("fet_w%0d", i), fetch_data[i*32 +: 32], exp_q.pop_front());
    @(negedge clk_in);

    // Simultaneous requests, twice.
    applyStimulus(1, 0, 2'd2, 32'h100, 32'd0, 1, 32'h1000);
    @(negedge clk_in);
    checkOutput("arb1_winner", mem_a, 32'h100);
    waitDone(0, "arb1");
    lsb_req = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk_in);
    applyStimulus(1, 0, 2'd2, 32'h100, 32'd0, 1, 32'h1000);
    @(negedge clk_in);
    checkOutput("arb2_winner", mem_a, RR ? 32'h1000 : 32'h100);
    waitDone(RR, "arb2");
    lsb_req = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk_in);

    // Flush a fetch at byte 5 with a load waiting behind it.
    applyStimulus(0, 0, 2'd0, 32'd0, 32'd0, 1, 32'h2000);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (c == 3) begin
        applyStimulus(1, 0, 2'd0, 32'h100, 32'd0, 1, 32'h2000);
        exp_q.push_back(32'h00000011);
      end
    end
    checkOutput("fl_a5", mem_a, 32'h2005);
    fetch_flush = 1'b1;
    fetch_req = 1'b0;
    @(negedge clk_in);
    checkOutput("fl_idle_a", mem_a, 32'd0);
    checkOutput("fl_idle_fdone", 32'(fetch_done), 32'd0);
    fetch_flush = 1'b0;
    @(negedge clk_in);
    checkOutput("fl_lsb_a", mem_a, 32'h100);
    @(negedge clk_in);
    checkOutput("fl_lsb_drain", mem_a, 32'd0);
    @(negedge clk_in);
    checkOutput("fl_lsb_done", 32'(lsb_done), 32'd1);
    checkOutput("fl_fdone", 32'(fetch_done), 32'd0);
    checkOutput("fl_rdata", lsb_rdata, exp_q.pop_front());
    lsb_req = 1'b0;
    @(negedge clk_in);

    // Reset in the middle of a word store.
    applyStimulus(1, 1, 2'd2, 32'h300, 32'hCAFEF00D, 0, 32'd0);
    @(negedge clk_in);
    checkOutput("rs_d1", 32'(mem_dout), 32'h0D);
    @(negedge clk_in);
    checkOutput("rs_wr2", 32'(mem_wr), 32'd1);
    checkOutput("rs_d2", 32'(mem_dout), 32'hF0);
    rst_in = 1'b1;
    lsb_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("rs_wr", 32'(mem_wr), 32'd0);
    checkOutput("rs_a", mem_a, 32'd0);
    checkOutput("rs_done", 32'(lsb_done), 32'd0);
    checkOutput("rs_rdata", lsb_rdata, 32'd0);
    checkOutput("rs_fdata", fetch_data[31:0], 32'd0);
    @(negedge clk_in);
    checkOutput("rs_idle_wr", 32'(mem_wr), 32'd0);
    checkOutput("rs_idle_done", 32'(lsb_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
